// File: rtl/vender_credit_fsm.sv
// Coin-operated vend controller: accumulates credit from J/Y/Q coins, vends at PRICE, pays change/refunds in CHANGE_UNIT pulses.
// Latency: one edge from the completing coin to open; outputs are decoded from registers only.
// Backpressure: none; coins that cannot be credited are returned via a one-cycle coin_reject pulse.
module vender_credit_fsm #(
  parameter int CREDIT_W     = 8,
  parameter int COIN_J       = 5,
  parameter int COIN_Y       = 10,
  parameter int COIN_Q       = 25,
  parameter int PRICE        = 15,
  parameter int CHANGE_UNIT  = 5,
  parameter int MAX_CREDIT   = 40,
  parameter int VEND_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                J,
  input  logic                Y,
  input  logic                Q,
  input  logic                cancel,
  input  logic                taken,
  output logic                open,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // State encoding kept as plain constants so legacy tools can consume it.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;

  // One extra bit on the sum so credit+coin can never wrap before the limit compare.
  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [SUM_W-1:0]    J_VAL    = SUM_W'(COIN_J);
  localparam logic [SUM_W-1:0]    Y_VAL    = SUM_W'(COIN_Y);
  localparam logic [SUM_W-1:0]    Q_VAL    = SUM_W'(COIN_Q);
  localparam logic [SUM_W-1:0]    PRICE_V  = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]    MAX_V    = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] UNIT_V   = CREDIT_W'(CHANGE_UNIT);
  localparam logic [7:0]          TO_LAST  = 8'(VEND_TIMEOUT - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [7:0]          vend_cnt;
  logic [7:0]          vend_cnt_nxt;
  logic                reject_nxt;

  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    credit_sum;
  logic [SUM_W-1:0]    credit_new;
  logic                collecting;
  logic                coin_ok;

  // Coin decode: how many coins arrived this cycle and what a single coin is worth.
  always_comb begin
    coin_cnt = {1'b0, J} + {1'b0, Y} + {1'b0, Q};
    coin_any = J | Y | Q;
    coin_val = '0;
    if (J) begin
      coin_val = J_VAL;
    end else if (Y) begin
      coin_val = Y_VAL;
    end else if (Q) begin
      coin_val = Q_VAL;
    end
    credit_sum = {1'b0, credit} + coin_val;
    collecting = (state == S_IDLE) || (state == S_COLLECT);
    // A coin only counts when it is alone, not fighting a cancel, and fits under the ceiling.
    coin_ok    = collecting && (coin_cnt == 2'd1) && !cancel && (credit_sum <= MAX_V);
    credit_new = coin_ok ? credit_sum : {1'b0, credit};
    // Anything that arrived and was not credited goes back to the customer.
    reject_nxt = coin_any && !coin_ok;
  end

  // Next-state and datapath: collect, vend with door timeout, then pay out in units.
  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    vend_cnt_nxt = vend_cnt;
    case (state)
      S_IDLE, S_COLLECT: begin
        if ((state == S_COLLECT) && cancel) begin
          // Any coin seen alongside cancel was rejected, so refund exactly what was held.
          state_nxt = S_REFUND;
        end else if (credit_new >= PRICE_V) begin
          state_nxt    = S_VEND;
          credit_nxt   = CREDIT_W'(credit_new - PRICE_V);
          vend_cnt_nxt = '0;
        end else if (credit_new != '0) begin
          state_nxt  = S_COLLECT;
          credit_nxt = CREDIT_W'(credit_new);
        end else begin
          state_nxt  = S_IDLE;
          credit_nxt = '0;
        end
      end
      S_VEND: begin
        if (taken || (vend_cnt == TO_LAST)) begin
          vend_cnt_nxt = '0;
          state_nxt    = (credit != '0) ? S_CHANGE : S_IDLE;
        end else begin
          vend_cnt_nxt = vend_cnt + 8'd1;
        end
      end
      S_CHANGE, S_REFUND: begin
        // Last unit clears credit; the <= also guards against a non-multiple residue.
        if (credit <= UNIT_V) begin
          credit_nxt = '0;
          state_nxt  = S_IDLE;
        end else begin
          credit_nxt = credit - UNIT_V;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        credit_nxt   = '0;
        vend_cnt_nxt = '0;
      end
    endcase
  end

  // State, credit, door timer and reject flag registers; reset drops any owed change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      vend_cnt    <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend_cnt    <= vend_cnt_nxt;
      coin_reject <= reject_nxt;
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    open         = (state == S_VEND);
    change_pulse = (state == S_CHANGE) || (state == S_REFUND);
    busy         = open || change_pulse;
  end

endmodule
